// File: rtl/eight_reg_axil_seq_pkg.sv
// Shared types and constants for the eight-register AXI4-Lite write/read-back sequencer.
package eight_reg_axil_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_RESP,
        S_RD_REQ,
        S_RD_RESP,
        S_FIN
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int ERR_W = 8;
    localparam int IDX_W = 5;

    function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/eight_reg_axil_sequencer.sv
// AXI4-Lite master that writes SEED+i to NUM_REGS consecutive registers, reads them
// back, and reports how many responses or read values were wrong.
module eight_reg_axil_sequencer
    import eight_reg_axil_seq_pkg::*;
#(
    parameter int          C_M_AXI_ADDR_WIDTH = 32,
    parameter int          C_M_AXI_DATA_WIDTH = 32,
    parameter int          NUM_REGS           = 8,
    parameter logic [31:0] BASE_ADDR          = 32'h0000_0000,
    parameter logic [31:0] SEED               = 32'h0000_0001
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic                              pass,
    output logic [ERR_W-1:0]                  err_cnt,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;

    function automatic logic [AW-1:0] reg_addr(input logic [IDX_W-1:0] i);
        return AW'(BASE_ADDR) + (AW'(i) << 2);
    endfunction

    function automatic logic [DW-1:0] reg_data(input logic [IDX_W-1:0] i);
        return DW'(SEED + 32'(i));
    endfunction

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [AW-1:0]      awaddr_q, awaddr_d;
    logic [DW-1:0]      wdata_q, wdata_d;
    logic               awvalid_q, awvalid_d;
    logic               wvalid_q, wvalid_d;
    logic               bready_q, bready_d;
    logic [AW-1:0]      araddr_q, araddr_d;
    logic               arvalid_q, arvalid_d;
    logic               rready_q, rready_d;

    logic [IDX_W-1:0]   idx_inc;
    logic               idx_last;

    assign idx_inc  = idx_q + 1'b1;
    assign idx_last = (idx_q == IDX_W'(NUM_REGS - 1));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        err_d     = err_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        araddr_d  = araddr_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_WR_REQ;
                    idx_d     = '0;
                    err_d     = '0;
                    pass_d    = 1'b0;
                    busy_d    = 1'b1;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    awaddr_d  = reg_addr('0);
                    wdata_d   = reg_data('0);
                end
            end
            S_WR_REQ: begin
                if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
                // A channel whose valid already dropped has completed its handshake.
                if ((!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY)) begin
                    state_d  = S_WR_RESP;
                    bready_d = 1'b1;
                end
            end
            S_WR_RESP: begin
                if (M_AXI_BVALID) begin
                    bready_d = 1'b0;
                    if (M_AXI_BRESP != RESP_OKAY) err_d = err_sat_inc(err_q);
                    if (idx_last) begin
                        state_d   = S_RD_REQ;
                        idx_d     = '0;
                        arvalid_d = 1'b1;
                        araddr_d  = reg_addr('0);
                    end else begin
                        state_d   = S_WR_REQ;
                        idx_d     = idx_inc;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = reg_addr(idx_inc);
                        wdata_d   = reg_data(idx_inc);
                    end
                end
            end
            S_RD_REQ: begin
                if (M_AXI_ARREADY) begin
                    state_d   = S_RD_RESP;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            S_RD_RESP: begin
                if (M_AXI_RVALID) begin
                    rready_d = 1'b0;
                    if ((M_AXI_RDATA != reg_data(idx_q)) || (M_AXI_RRESP != RESP_OKAY))
                        err_d = err_sat_inc(err_q);
                    if (idx_last) begin
                        // Status is registered on entry so done, pass and busy change together in FIN.
                        state_d = S_FIN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        pass_d  = (err_d == '0);
                    end else begin
                        state_d   = S_RD_REQ;
                        idx_d     = idx_inc;
                        arvalid_d = 1'b1;
                        araddr_d  = reg_addr(idx_inc);
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            err_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            araddr_q  <= araddr_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_cnt       = err_q;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_eight_reg_axil_sequencer.sv
// Scoreboard bench: a behavioural AXI4-Lite slave with fault knobs drives the sequencer.
module tb_eight_reg_axil_sequencer;

    localparam int          N    = 8;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [31:0] SEED = 32'h0000_0001;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, pass;
    logic [7:0]  err_cnt;
    logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR;
    logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
    logic        M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_BVALID = 1'b0;
    logic        M_AXI_ARREADY = 1'b0, M_AXI_RVALID = 1'b0;
    logic [1:0]  M_AXI_BRESP = 2'b00, M_AXI_RRESP = 2'b00;
    logic [31:0] M_AXI_RDATA = 32'h0;

    eight_reg_axil_sequencer dut (
        .ACLK(ACLK), .ARESET(ARESET), .start(start), .busy(busy), .done(done),
        .pass(pass), .err_cnt(err_cnt),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 ACLK = ~ACLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave fault knobs
    int aw_delay = 0;
    int corrupt_idx = -1;
    int slverr_idx = -1;

    logic [31:0] mem [0:15];
    logic [63:0] exp_wr_q [$];
    logic [31:0] exp_rd_q [$];

    bit          aw_got, w_got, bpend, rpend;
    logic [31:0] aw_a, w_d, aw_first;
    int          b_idx, r_idx, aw_wait;
    int          wr_cnt, b_cnt, ar_cnt, r_cnt, done_cnt;
    int          aw_hold, w_hold, last_aw_hold, last_w_hold, aw_unstable;

    // Monitor / scoreboard: reads pre-edge values at each rising edge.
    always @(posedge ACLK) begin
        logic [63:0] e;
        logic [31:0] ea;
        if (ARESET) begin
            aw_got = 0; w_got = 0; bpend = 0; rpend = 0; aw_hold = 0; w_hold = 0;
        end else begin
            if (M_AXI_AWVALID) begin
                if (aw_hold == 0) aw_first = M_AXI_AWADDR;
                else if (M_AXI_AWADDR != aw_first) aw_unstable++;
                aw_hold++;
            end
            if (M_AXI_WVALID) w_hold++;
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                aw_got = 1; aw_a = M_AXI_AWADDR; last_aw_hold = aw_hold; aw_hold = 0;
            end
            if (M_AXI_WVALID && M_AXI_WREADY) begin
                w_got = 1; w_d = M_AXI_WDATA; last_w_hold = w_hold; w_hold = 0;
            end
            if (aw_got && w_got) begin
                aw_got = 0; w_got = 0;
                if (exp_wr_q.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    e = exp_wr_q.pop_front();
                    chk("wr_addr", aw_a, e[63:32]);
                    chk("wr_data", w_d, e[31:0]);
                end
                mem[aw_a[5:2]] = w_d;
                b_idx = int'(aw_a[5:2]);
                bpend = 1;
                wr_cnt++;
            end
            if (M_AXI_BVALID && M_AXI_BREADY) begin
                bpend = 0; b_cnt++;
            end
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                chk("rd_overlap", {M_AXI_AWVALID, M_AXI_WVALID, bpend}, 0);
                if (exp_rd_q.size() == 0) chk("rd_unexpected", 1, 0);
                else begin
                    ea = exp_rd_q.pop_front();
                    chk("rd_addr", M_AXI_ARADDR, ea);
                end
                r_idx = int'(M_AXI_ARADDR[5:2]);
                rpend = 1;
                ar_cnt++;
            end
            if (M_AXI_RVALID && M_AXI_RREADY) begin
                rpend = 0; r_cnt++;
            end
            if (done) done_cnt++;
        end
    end

    // Slave driver: updates on the falling edge so it never races the DUT.
    always @(negedge ACLK) begin
        if (M_AXI_AWVALID) begin
            if (aw_wait >= aw_delay) M_AXI_AWREADY = 1'b1;
            else begin
                M_AXI_AWREADY = 1'b0;
                aw_wait++;
            end
        end else begin
            M_AXI_AWREADY = 1'b0;
            aw_wait = 0;
        end
        M_AXI_WREADY  = M_AXI_WVALID;
        M_AXI_BVALID  = bpend;
        M_AXI_BRESP   = (bpend && b_idx == slverr_idx) ? 2'b10 : 2'b00;
        M_AXI_ARREADY = M_AXI_ARVALID;
        M_AXI_RVALID  = rpend;
        M_AXI_RDATA   = !rpend ? 32'h0 : (r_idx == corrupt_idx) ? 32'h0000_DEAD : mem[r_idx];
        M_AXI_RRESP   = (rpend && r_idx == slverr_idx) ? 2'b10 : 2'b00;
    end

    task automatic arm(input int awd, input int cor, input int sle);
        aw_delay = awd; corrupt_idx = cor; slverr_idx = sle;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        for (int i = 0; i < N; i++) begin
            exp_wr_q.push_back({BASE + 32'(4 * i), SEED + 32'(i)});
            exp_rd_q.push_back(BASE + 32'(4 * i));
        end
        wr_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0; done_cnt = 0;
        aw_unstable = 0;
    endtask

    // Called at a falling edge; start is raised immediately.
    task automatic run_seq(input string name, input int awd, input int cor, input int sle,
                           input int exp_err, input bit spam);
        int t;
        arm(awd, cor, sle);
        start = 1'b1;
        @(negedge ACLK);
        if (spam) repeat (20) @(negedge ACLK);
        start = 1'b0;
        t = 0;
        while (done_cnt == 0 && t < 1000) begin
            @(negedge ACLK);
            t++;
        end
        chk({name, "_done_seen"}, done_cnt > 0, 1);
        chk({name, "_pass"}, pass, exp_err == 0);
        chk({name, "_err_cnt"}, err_cnt, exp_err);
        chk({name, "_busy_low"}, busy, 0);
        repeat (5) @(negedge ACLK);
        chk({name, "_done_once"}, done_cnt, 1);
        chk({name, "_writes"}, wr_cnt, N);
        chk({name, "_bresps"}, b_cnt, N);
        chk({name, "_reads"}, ar_cnt, N);
        chk({name, "_rbeats"}, r_cnt, N);
        chk({name, "_sb_empty"}, exp_wr_q.size() + exp_rd_q.size(), 0);
        chk({name, "_pass_held"}, pass, exp_err == 0);
        chk({name, "_err_held"}, err_cnt, exp_err);
        $display("run %s: err_cnt=%0d pass=%0d writes=%0d reads=%0d", name, err_cnt, pass, wr_cnt, r_cnt);
    endtask

    initial begin
        int t;
        ARESET = 1'b1;
        repeat (3) @(negedge ACLK);
        chk("rst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 0);
        chk("rst_status", {busy, done, pass}, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_addr_data", {M_AXI_AWADDR, M_AXI_WDATA}, 0);
        ARESET = 1'b0;
        @(negedge ACLK);

        run_seq("basic", 0, -1, -1, 0, 0);
        for (int i = 0; i < N; i++) chk("basic_mem", mem[i], SEED + 32'(i));
        chk("basic_strb_prot", {M_AXI_WSTRB, M_AXI_AWPROT, M_AXI_ARPROT}, {4'hF, 6'b0});

        run_seq("aw_delay", 3, -1, -1, 0, 0);
        chk("aw_hold_cycles", last_aw_hold, 4);
        chk("w_hold_cycles", last_w_hold, 1);
        chk("aw_addr_stable", aw_unstable, 0);

        run_seq("corrupt2", 0, 2, -1, 1, 0);
        run_seq("slverr5", 0, -1, 5, 2, 0);

        // Reset while read 4 is waiting for its data beat.
        arm(0, -1, -1);
        start = 1'b1;
        @(negedge ACLK);
        start = 1'b0;
        t = 0;
        while (!(M_AXI_RREADY && M_AXI_ARADDR == BASE + 32'h10) && t < 500) begin
            @(negedge ACLK);
            t++;
        end
        chk("midrst_reached", t < 500, 1);
        ARESET = 1'b1;
        @(negedge ACLK);
        chk("midrst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 0);
        chk("midrst_busy_done", {busy, done}, 0);
        chk("midrst_no_done", done_cnt, 0);
        $display("run midrst: reset during read 4, busy=%0d done=%0d", busy, done);
        exp_wr_q.delete();
        exp_rd_q.delete();
        ARESET = 1'b0;
        run_seq("after_rst", 0, -1, -1, 0, 0);

        @(negedge ACLK);
        run_seq("start_spam", 0, -1, -1, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
